bin_to_bcd_iter: RTL

BIN_TO_BCD_ITER -- requirements
Module: bin_to_bcd_iter

---
 rtl/bin_to_bcd_iter.sv | 102 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter: one shift per clock, fixed BIN_W+2 cycle period.
// Define BIN_TO_BCD_ITER_SIGNED_EN to treat bin_in as two's complement (magnitude converted, sign on neg).

module bin_to_bcd_adj3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_iter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  neg
);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [DIGITS-1:0][3:0] acc_q, acc_adj, acc_d;
    logic [BIN_W-1:0]       opnd_q, opnd_d, mag;
    logic                   ovf_q, sign_q, sign_in, carry, last, ovf_nxt;

`ifdef BIN_TO_BCD_ITER_SIGNED_EN
    assign sign_in = bin_in[BIN_W-1];
    assign mag     = sign_in ? (~bin_in) + BIN_W'(1) : bin_in;
`else
    assign sign_in = 1'b0;
    assign mag     = bin_in;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bin_to_bcd_adj3 u_adj (.d(acc_q[i]), .q(acc_adj[i]));
    end

    // The bit leaving the top digit means the value no longer fits in DIGITS digits.
    assign {carry, acc_d, opnd_d} = {acc_adj, opnd_q, 1'b0};
    assign last    = (cnt_q == CW'(1));
    assign ovf_nxt = ovf_q | carry;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results are registered on the final shift edge so they are valid for the whole DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE && start) begin
                acc_q  <= '0;
                opnd_q <= mag;
                ovf_q  <= 1'b0;
                sign_q <= sign_in;
                cnt_q  <= CW'(BIN_W);
            end else if (state_q == SHIFT) begin
                acc_q  <= acc_d;
                opnd_q <= opnd_d;
                ovf_q  <= ovf_nxt;
                cnt_q  <= cnt_q - CW'(1);
                if (last) begin
                    done    <= 1'b1;
                    bcd_out <= ovf_nxt ? {DIGITS{4'h9}} : acc_d;
                    ovf     <= ovf_nxt;
                    neg     <= sign_q;
                end
            end
        end
    end
endmodule
